// File: rtl/mem_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_fifo_ctrl_pkg
// Brief    : Shared sizing defaults and depth derivation for the FIFO
//            controller and the memory it drives.
// Revision : 1.0 - initial release
// ============================================================================
package mem_fifo_ctrl_pkg;

    localparam int c_ADDR_SIZE_DEFAULT = 4;
    localparam int c_BYTE_SIZE_DEFAULT = 8;

    // Number of memory entries addressed by an addr_size-bit pointer.
    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_fifo_ctrl
// Brief    : Valid/ready FIFO controller around an external memory with
//            combinational read data. Holds only the pointers and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = c_ADDR_SIZE_DEFAULT,
    parameter int BYTE_SIZE = c_BYTE_SIZE_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BYTE_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BYTE_SIZE-1:0] out_data,
    output logic [ADDR_SIZE:0]   count,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic [BYTE_SIZE-1:0] mem_wdata,
    output logic [ADDR_SIZE-1:0] mem_raddr,
    input  logic [BYTE_SIZE-1:0] mem_rdata
);

    localparam logic [ADDR_SIZE:0] c_DEPTH = (ADDR_SIZE+1)'(fifo_depth(ADDR_SIZE));

    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    // Handshake flags come straight from the occupancy register, so a pop
    // on a full queue only frees a slot from the following cycle.
    assign in_ready  = (r_count != c_DEPTH);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Reset and flush both discard the cycle's push, so the memory must not
    // be written either.
    assign mem_wen   = w_push & ~reset & ~flush;
    assign mem_waddr = r_wr_ptr;
    assign mem_wdata = in_data;
    assign mem_raddr = r_rd_ptr;
    assign out_data  = mem_rdata;
    assign count     = r_count;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_fifo_ctrl
// Brief    : Self-checking bench for mem_fifo_ctrl with an attached behavioural
//            memory and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_fifo_ctrl;
    import mem_fifo_ctrl_pkg::*;

    localparam int AW    = 2;
    localparam int BW    = 8;
    localparam int DEPTH = fifo_depth(AW);

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid, mem_wen;
    logic [BW-1:0] in_data, out_data, mem_wdata, mem_rdata;
    logic [AW:0]   count;
    logic [AW-1:0] mem_waddr, mem_raddr;

    logic [BW-1:0] mem [DEPTH];

    int            n_cmp = 0;
    int            n_err = 0;
    logic [BW-1:0] q[$];
    bit            known = 1'b0;

    always #5 clock = ~clock;

    // Attached memory: synchronous write, asynchronous read.
    always @(posedge clock) if (mem_wen) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    mem_fifo_ctrl #(.ADDR_SIZE(AW), .BYTE_SIZE(BW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit r, input bit f, input bit iv, input logic [BW-1:0] d, input bit ordy);
        bit acc;
        bit tk;
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clock);
        acc = iv && (q.size() < DEPTH);
        tk  = ordy && (q.size() > 0);
        if (known) begin
            chk("in_ready",  in_ready,  q.size() < DEPTH);
            chk("out_valid", out_valid, q.size() > 0);
            chk("count",     count,     q.size());
            chk("mem_wen",   mem_wen,   acc && !r && !f);
            if (q.size() > 0) chk("out_data", out_data, q[0]);
            if (acc && !r && !f) chk("mem_wdata", mem_wdata, d);
        end
        @(posedge clock);
        #1;
        if (r) begin
            q.delete();
            known = 1'b1;
        end else if (f) begin
            q.delete();
        end else if (known) begin
            if (tk) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);

        // Three back-to-back pushes, then drain in order.
        cycle(0, 0, 1, 8'h11, 0);
        cycle(0, 0, 1, 8'h22, 0);
        cycle(0, 0, 1, 8'h33, 0);
        cycle(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 0);

        // Fill to full, offer a fifth word, pop while full, then refill.
        for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 8'(i), 0);
        cycle(0, 0, 1, 8'h05, 0);
        cycle(0, 0, 1, 8'h06, 1);
        cycle(0, 0, 1, 8'h07, 0);
        cycle(0, 0, 0, 8'h00, 0);

        // One queued word, then ten cycles of simultaneous push and pop.
        cycle(1, 0, 0, 8'h00, 0);
        cycle(0, 0, 1, 8'h9F, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 8'(8'hA0 + i), 1);
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 0);

        // Flush with three queued words and a pending push.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'(8'hC0 + i), 0);
        cycle(0, 1, 1, 8'hEE, 1);
        cycle(0, 0, 1, 8'h5A, 0);
        cycle(0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 1);

        // Reset mid-stream with a pending push.
        cycle(0, 0, 1, 8'h61, 0);
        cycle(0, 0, 1, 8'h62, 0);
        cycle(1, 0, 1, 8'h63, 1);
        cycle(0, 0, 0, 8'h00, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_fifo_ctrl.md
MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, memory address width; DEPTH = 2**ADDR_SIZE entries.
REQ-002 SHALL have parameter BYTE_SIZE, default 8, data word width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of queue contents (pointers/count only).
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  controller accepts a word this cycle.
REQ-008 SHALL have port in_data  input  BYTE_SIZE  word to enqueue.
REQ-009 SHALL have port out_valid  output  1  out_data holds the oldest queued word.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port out_data  output  BYTE_SIZE  oldest queued word.
REQ-012 SHALL have port count  output  ADDR_SIZE+1  number of queued words, 0..DEPTH.
REQ-013 SHALL have port mem_wen  output  1  write enable to the attached memory.
REQ-014 SHALL have port mem_waddr  output  ADDR_SIZE  write address to the attached memory.
REQ-015 SHALL have port mem_wdata  output  BYTE_SIZE  write data to the attached memory.
REQ-016 SHALL have port mem_raddr  output  ADDR_SIZE  read address to the attached memory.
REQ-017 SHALL have port mem_rdata  input  BYTE_SIZE  combinational (asynchronous) read data from the attached memory.

Function
REQ-018 SHALL hold registers wr_ptr, rd_ptr (ADDR_SIZE bits each) and count (ADDR_SIZE+1 bits).
REQ-019 SHALL drive in_ready = (count != DEPTH) and out_valid = (count != 0), combinationally from registers only.
REQ-020 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-021 SHALL drive mem_wen = push, mem_waddr = wr_ptr, mem_wdata = in_data combinationally; the memory commits on the same posedge.
REQ-022 SHALL drive mem_raddr = rd_ptr and out_data = mem_rdata combinationally.
REQ-023 SHALL on push increment wr_ptr modulo DEPTH (DEPTH-1 wraps to 0); SHALL on pop increment rd_ptr modulo DEPTH.
REQ-024 SHALL update count: +1 on push only, -1 on pop only, unchanged on push & pop or neither.
REQ-025 SHALL give write-to-read latency of 1 cycle: a word pushed into an empty queue at edge N appears on out_data with out_valid=1 after edge N.
REQ-026 SHALL, when full, refuse push (in_ready=0) even if out_ready=1 the same cycle; in_ready rises the cycle after the pop.
REQ-027 SHALL, when empty, never pop; simultaneous in_valid is a push only.
REQ-028 SHALL on flush=1 (reset=0) set wr_ptr, rd_ptr, count to 0 at the next edge, suppressing mem_wen and ignoring pop that cycle.
REQ-029 SHALL preserve FIFO order across pointer wrap for any DEPTH.

Reset
REQ-030 SHALL on reset=1 at posedge set wr_ptr=0, rd_ptr=0, count=0; outputs thereafter in_ready=1, out_valid=0, count=0, mem_wen=0.
REQ-031 SHALL force mem_wen=0 while reset=1; reset takes priority over flush, push, pop; reset mid-stream discards all queued words.
REQ-032 SHALL NOT clear memory contents on reset or flush.

Structure
REQ-033 SHALL place the DEPTH derivation and default ADDR_SIZE/BYTE_SIZE values in the shared package/include used with the memory module.
REQ-034 SHALL instantiate no storage; the existing memory module is instantiated alongside by the parent and wired via mem_* ports.
REQ-035 SHALL need no sub-module; the wrapping pointer increment is written inline.

Verification
REQ-036 Reset, then push 0x11,0x22,0x33 back-to-back with out_ready=0 -> count=3, out_data=0x11, out_valid=1.
REQ-037 Then out_ready=1 for 3 cycles -> out_data 0x11,0x22,0x33 in order; count=0, out_valid=0.
REQ-038 ADDR_SIZE=2: push 0x01..0x04 -> in_ready=0, count=4; a fifth in_valid is not accepted; one pop -> in_ready=1 next cycle.
REQ-039 ADDR_SIZE=2: 10 cycles simultaneous push/pop, data 0xA0..0xA9, starting with 1 word queued -> count stays 1, pointers wrap, outputs in order.
REQ-040 Queue holding 3 words, assert flush one cycle -> count=0, out_valid=0, mem_wen=0 that cycle; next push 0x5A reads back 0x5A.
REQ-041 Reset asserted with count=2 and in_valid=1 -> mem_wen=0, count=0 after edge, in_ready=1.
